// File: rtl/sap_pkg.sv
// Shared definitions for the SAP front-panel blocks: default widths and the
// programmer FSM state encoding.
package sap_pkg;

    localparam int SAP_DATA_W = 8;
    localparam int SAP_ADDR_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_INC,
        ST_REL
    } prog_state_e;

endpackage

// File: rtl/btn_oneshot.sv
// Two-flop synchroniser plus a history flop for a raw front-panel button;
// sync is the clean level, rise is a one-cycle pulse on its rising edge.
module btn_oneshot (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic sync,
    output logic rise
);

    logic s1, s2, s3;

    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge value of its neighbour; blocking here would
    // collapse the synchroniser chain into a single stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sync = s2;
    assign rise = s2 & ~s3;

endmodule

// File: rtl/ram_mar_prog.sv
// SAP memory address register and RAM on the shared tri-state bus, with a
// front-panel programmer (one-shot write button, optional auto-increment).
module ram_mar_prog
    import sap_pkg::*;
#(
    parameter int DATA_W = SAP_DATA_W,
    parameter int ADDR_W = SAP_ADDR_W
) (
    input  logic              clk,
    input  logic              cls,
    input  logic              prog_run,
    input  logic              mar_in,
    input  logic              ram_in,
    input  logic              ram_out,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic              prog_load,
    input  logic [DATA_W-1:0] prog_dat,
    input  logic              wr_btn,
    input  logic              auto_inc,
    inout  wire  [DATA_W-1:0] BUS,
    output logic [ADDR_W-1:0] mar_q,
    output logic [ADDR_W-1:0] pa_q,
    output logic [DATA_W-1:0] ram_q,
    output logic              wr_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] mar, pa, addr;
    prog_state_e       state, state_nxt;
    logic              btn_sync, btn_rise;
    logic              run_we, prog_we;

    btn_oneshot u_wr_btn (
        .clk   (clk),
        .rst_n (cls),
        .btn   (wr_btn),
        .sync  (btn_sync),
        .rise  (btn_rise)
    );

    always_ff @(posedge clk or negedge cls) begin
        if (!cls) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // NOTE: next state gets its default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (btn_rise)  state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = auto_inc ? ST_INC : ST_REL;
            ST_INC:   state_nxt = ST_REL;
            ST_REL:   if (!btn_sync) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        // Switching to run mode abandons any programming sequence.
        if (prog_run) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or negedge cls) begin
        if (!cls) begin
            mar <= '0;
            pa  <= '0;
        end else begin
            if (prog_run && mar_in) mar <= BUS[ADDR_W-1:0];
            // A panel load overrides a pending auto-increment.
            if (!prog_run && prog_load) pa <= prog_addr;
            else if (state == ST_INC)   pa <= pa + ADDR_W'(1);
        end
    end

    assign run_we  = prog_run & ram_in;
    assign prog_we = (state == ST_WRITE);

    // NOTE: the RAM array has no reset branch; its contents are undefined
    // after power-up and clearing it would prevent block-RAM inference.
    always_ff @(posedge clk) begin
        if (run_we)       mem[mar] <= BUS;
        else if (prog_we) mem[pa]  <= prog_dat;
    end

    assign addr    = prog_run ? mar : pa;
    assign ram_q   = mem[addr];
    assign BUS     = ram_out ? ram_q : {DATA_W{1'bz}};
    assign mar_q   = mar;
    assign pa_q    = pa;
    assign wr_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_ram_mar_prog.sv
// Directed bench for ram_mar_prog: expectations are queued when stimulus is
// driven and popped when the corresponding output is sampled.
module tb_ram_mar_prog;

    logic       clk = 1'b0;
    logic       cls = 1'b0;
    logic       prog_run = 1'b1;
    logic       mar_in = 1'b0;
    logic       ram_in = 1'b0;
    logic       ram_out = 1'b0;
    logic [3:0] prog_addr = '0;
    logic       prog_load = 1'b0;
    logic [7:0] prog_dat = '0;
    logic       wr_btn = 1'b0;
    logic       auto_inc = 1'b0;
    logic       drv_en = 1'b0;
    logic [7:0] drv_val = '0;
    wire  [7:0] bus;
    logic [3:0] mar_q, pa_q;
    logic [7:0] ram_q;
    logic       wr_busy;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];

    assign bus = drv_en ? drv_val : 8'bz;

    always #5 clk = ~clk;

    ram_mar_prog dut (
        .clk       (clk),
        .cls       (cls),
        .prog_run  (prog_run),
        .mar_in    (mar_in),
        .ram_in    (ram_in),
        .ram_out   (ram_out),
        .prog_addr (prog_addr),
        .prog_load (prog_load),
        .prog_dat  (prog_dat),
        .wr_btn    (wr_btn),
        .auto_inc  (auto_inc),
        .BUS       (bus),
        .mar_q     (mar_q),
        .pa_q      (pa_q),
        .ram_q     (ram_q),
        .wr_busy   (wr_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        sb_item_t it;
        compared++;
        if (sb_q.size() == 0) begin
            mismatched++;
            $error("FAIL sb_empty: observed 0x%0h with no expectation queued", obs);
        end else begin
            it = sb_q.pop_front();
            assert (obs === it.exp)
            else begin
                mismatched++;
                $error("FAIL %s: observed 0x%0h expected 0x%0h", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic expect_now(input string tag, input logic [31:0] exp, input logic [31:0] obs);
        sb_push(tag, exp);
        sb_check(obs);
    endtask

    task automatic run_load_mar(input logic [3:0] a);
        drv_en = 1'b1; drv_val = {4'h0, a}; mar_in = 1'b1;
        tick();
        mar_in = 1'b0; drv_en = 1'b0;
    endtask

    task automatic run_write(input logic [7:0] d);
        drv_en = 1'b1; drv_val = d; ram_in = 1'b1;
        tick();
        ram_in = 1'b0; drv_en = 1'b0;
    endtask

    task automatic load_pa(input logic [3:0] a);
        prog_addr = a; prog_load = 1'b1;
        tick();
        prog_load = 1'b0;
    endtask

    // Press for hold_cycles (>= 3), checking the press-to-busy latency, then
    // wait (bounded) for the programmer to return to idle.
    task automatic press(input int hold_cycles);
        wr_btn = 1'b1;
        tick();
        tick();
        expect_now("busy_before_write", 0, wr_busy);
        tick();
        expect_now("busy_at_write", 1, wr_busy);
        repeat (hold_cycles - 3) tick();
        wr_btn = 1'b0;
        for (int i = 0; i < 20 && wr_busy; i++) tick();
        expect_now("busy_cleared", 0, wr_busy);
    endtask

    initial begin
        // Reset held with random control activity.
        drv_en = 1'b1; drv_val = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            prog_run  = 1'($urandom_range(0, 1));
            mar_in    = 1'($urandom_range(0, 1));
            ram_in    = 1'($urandom_range(0, 1));
            prog_load = 1'($urandom_range(0, 1));
            prog_addr = 4'($urandom_range(0, 15));
            wr_btn    = 1'($urandom_range(0, 1));
            auto_inc  = 1'($urandom_range(0, 1));
            tick();
        end
        expect_now("rst_mar", 0, mar_q);
        expect_now("rst_pa", 0, pa_q);
        expect_now("rst_busy", 0, wr_busy);
        expect_now("rst_bus_released", 8'h5A, bus);
        prog_run = 1'b1; mar_in = 1'b0; ram_in = 1'b0; prog_load = 1'b0;
        wr_btn = 1'b0; auto_inc = 1'b0; drv_en = 1'b0;
        cls = 1'b1;
        repeat (4) tick();

        // Run-mode write and read-back.
        run_load_mar(4'h3);
        expect_now("mar_load", 4'h3, mar_q);
        run_write(8'hA5);
        ram_out = 1'b1;
        #1;
        expect_now("run_read_bus", 8'hA5, bus);
        ram_out = 1'b0;

        // Simultaneous mar_in/ram_in writes at the old MAR.
        run_load_mar(4'h7);
        run_write(8'h66);
        run_load_mar(4'h3);
        drv_en = 1'b1; drv_val = 8'h07; mar_in = 1'b1; ram_in = 1'b1;
        tick();
        mar_in = 1'b0; ram_in = 1'b0; drv_en = 1'b0;
        expect_now("simul_mar", 4'h7, mar_q);
        expect_now("simul_new_addr_untouched", 8'h66, ram_q);
        run_load_mar(4'h3);
        expect_now("simul_old_addr_written", 8'h07, ram_q);

        // Program mode with auto-increment across the wrap.
        prog_run = 1'b0; auto_inc = 1'b1;
        load_pa(4'hE);
        expect_now("pa_load", 4'hE, pa_q);
        prog_dat = 8'h11;
        press(4);
        expect_now("pa_inc", 4'hF, pa_q);
        prog_dat = 8'h22;
        press(4);
        expect_now("pa_wrap", 4'h0, pa_q);
        load_pa(4'hE);
        expect_now("mem_e", 8'h11, ram_q);
        load_pa(4'hF);
        expect_now("mem_f", 8'h22, ram_q);

        // prog_load coinciding with INC wins over the increment.
        load_pa(4'hC);
        prog_dat = 8'h55;
        wr_btn = 1'b1;
        repeat (4) tick();
        expect_now("write_at_k3", 8'h55, ram_q);
        prog_addr = 4'h2; prog_load = 1'b1;
        tick();
        prog_load = 1'b0;
        expect_now("load_beats_inc", 4'h2, pa_q);
        wr_btn = 1'b0;
        for (int i = 0; i < 20 && wr_busy; i++) tick();
        expect_now("load_inc_idle", 0, wr_busy);

        // Held button: one write, busy until two cycles after release.
        load_pa(4'h5);
        prog_dat = 8'h33;
        wr_btn = 1'b1;
        repeat (20) tick();
        expect_now("held_busy", 1, wr_busy);
        expect_now("held_single_inc", 4'h6, pa_q);
        wr_btn = 1'b0;
        tick();
        expect_now("held_busy_rel1", 1, wr_busy);
        tick();
        expect_now("held_busy_rel2", 1, wr_busy);
        tick();
        expect_now("held_idle", 0, wr_busy);
        load_pa(4'h5);
        expect_now("held_mem", 8'h33, ram_q);

        // Mode switch when rise is seen: no write.
        auto_inc = 1'b0;
        load_pa(4'h9);
        prog_dat = 8'h44;
        press(4);
        expect_now("mem_9_init", 8'h44, ram_q);
        prog_dat = 8'h99;
        wr_btn = 1'b1;
        tick();
        tick();
        prog_run = 1'b1;
        tick();
        expect_now("switch_idle", 0, wr_busy);
        tick();
        expect_now("switch_stays_idle", 0, wr_busy);
        wr_btn = 1'b0;
        repeat (3) tick();
        prog_run = 1'b0;
        #1;
        expect_now("switch_mem_kept", 8'h44, ram_q);

        // Presses in run mode are ignored.
        prog_run = 1'b1; prog_dat = 8'hEE;
        wr_btn = 1'b1;
        repeat (5) tick();
        expect_now("run_btn_idle", 0, wr_busy);
        wr_btn = 1'b0;
        repeat (4) tick();
        prog_run = 1'b0;
        #1;
        expect_now("run_btn_mem_kept", 8'h44, ram_q);
        expect_now("run_btn_pa_kept", 4'h9, pa_q);

        // Run controls are ignored in program mode.
        drv_en = 1'b1; drv_val = 8'hFF; ram_in = 1'b1; mar_in = 1'b1;
        tick();
        ram_in = 1'b0; mar_in = 1'b0; drv_en = 1'b0;
        expect_now("prog_mar_hold", 4'h3, mar_q);
        expect_now("prog_ram_in_ignored", 8'h44, ram_q);
        prog_run = 1'b1;
        prog_addr = 4'h0; prog_load = 1'b1;
        tick();
        prog_load = 1'b0;
        expect_now("run_prog_load_ignored", 4'h9, pa_q);
        ram_out = 1'b1;
        #1;
        expect_now("run_mem_3_kept", 8'h07, bus);
        ram_out = 1'b0;
        tick();

        if (sb_q.size() != 0) begin
            compared++;
            mismatched++;
            $error("FAIL sb_leftover: observed %0d queued expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
